// File: rtl/cochlea_readout_scheduler_if.sv
// Output stream bundle from the cochlea readout scheduler to the serializer.
interface cochlea_readout_scheduler_if #(
    parameter int unsigned CH_W = 4
);
    localparam int unsigned DATA_W = CH_W + 4;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/cochlea_readout_scheduler.sv
// Frame-based readout scheduler: snapshots all channel I/Q readouts on an
// accepted frame tick, then streams one tagged word per selected channel.
module cochlea_readout_scheduler #(
    parameter int unsigned N_CH = 16,
    parameter int unsigned CH_W = 4
) (
    input  logic                clk_master,
    input  logic                rstb,
    input  logic                enable,
    input  logic                skip_zero,
    input  logic                frame_tick,
    input  logic [2*N_CH-1:0]   read_out_I,
    input  logic [2*N_CH-1:0]   read_out_Q,
    input  logic                clr_overrun,
    cochlea_readout_scheduler_if.master out_if,
    output logic                busy,
    output logic                overrun,
    output logic [7:0]          frame_count
);
    localparam int unsigned DATA_W = CH_W + 4;
    localparam int unsigned BUS_W  = 2 * N_CH;
    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     idx_q, idx_d;
    logic [BUS_W-1:0]    snap_i_q, snap_i_d;
    logic [BUS_W-1:0]    snap_q_q, snap_q_d;
    logic                skip_q, skip_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          frame_count_q, frame_count_d;

    logic [1:0]          cur_i;
    logic [1:0]          cur_q;
    logic                selected;
    logic                idx_is_last;

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            snap_i_q      <= '0;
            snap_q_q      <= '0;
            skip_q        <= 1'b0;
            valid_q       <= 1'b0;
            data_q        <= '0;
            last_q        <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            snap_i_q      <= snap_i_d;
            snap_q_q      <= snap_q_d;
            skip_q        <= skip_d;
            valid_q       <= valid_d;
            data_q        <= data_d;
            last_q        <= last_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Next-state and next-output logic for the IDLE/SCAN/EMIT sequencer.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        snap_i_d      = snap_i_q;
        snap_q_d      = snap_q_q;
        skip_d        = skip_q;
        valid_d       = valid_q;
        data_d        = data_q;
        last_d        = last_q;
        frame_count_d = frame_count_q;
        overrun_d     = overrun_q & ~clr_overrun;

        cur_i       = snap_i_q[{idx_q, 1'b0} +: 2];
        cur_q       = snap_q_q[{idx_q, 1'b0} +: 2];
        idx_is_last = (idx_q == LAST_IDX);
        // Last channel is always emitted so each frame carries an out_last word.
        selected    = ~skip_q | (|cur_i) | (|cur_q) | idx_is_last;

        case (state_q)
            IDLE: begin
                if (frame_tick && enable) begin
                    snap_i_d      = read_out_I;
                    snap_q_d      = read_out_Q;
                    skip_d        = skip_zero;
                    idx_d         = '0;
                    frame_count_d = frame_count_q + 8'd1;
                    state_d       = SCAN;
                end
            end
            SCAN: begin
                if (selected) begin
                    data_d  = {idx_q, cur_i, cur_q};
                    last_d  = idx_is_last;
                    valid_d = 1'b1;
                    state_d = EMIT;
                end else begin
                    idx_d = idx_q + CH_W'(1);
                end
            end
            EMIT: begin
                if (out_if.out_ready) begin
                    valid_d = 1'b0;
                    if (idx_is_last) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + CH_W'(1);
                        state_d = SCAN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        // A tick arriving mid-frame is dropped; flag it only when enabled.
        // Set takes priority over a simultaneous clear.
        if ((state_q != IDLE) && frame_tick && enable) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_last  = last_q;
    assign busy             = busy_q;
    assign overrun          = overrun_q;
    assign frame_count      = frame_count_q;

endmodule

// File: tb/tb_cochlea_readout_scheduler.sv
// Scoreboard bench for cochlea_readout_scheduler: stimulus pushes expected
// words, an independent monitor pops and compares on each handshake.
module tb_cochlea_readout_scheduler;
    localparam int unsigned N_CH = 16;
    localparam int unsigned CH_W = 4;
    localparam int unsigned BUS_W = 2 * N_CH;

    logic             clk_master = 1'b0;
    logic             rstb;
    logic             enable;
    logic             skip_zero;
    logic             frame_tick;
    logic [BUS_W-1:0] read_out_I;
    logic [BUS_W-1:0] read_out_Q;
    logic             clr_overrun;
    logic             busy;
    logic             overrun;
    logic [7:0]       frame_count;

    cochlea_readout_scheduler_if #(.CH_W(CH_W)) out_if ();

    cochlea_readout_scheduler #(.N_CH(N_CH), .CH_W(CH_W)) dut (
        .clk_master  (clk_master),
        .rstb        (rstb),
        .enable      (enable),
        .skip_zero   (skip_zero),
        .frame_tick  (frame_tick),
        .read_out_I  (read_out_I),
        .read_out_Q  (read_out_Q),
        .clr_overrun (clr_overrun),
        .out_if      (out_if.master),
        .busy        (busy),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    always #5 clk_master = ~clk_master;

    int n_vec  = 0;
    int n_miss = 0;
    int n_last = 0;
    int exp_fc = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every accepted word against the head of the scoreboard.
    always @(negedge clk_master) begin
        if (rstb && out_if.out_valid === 1'b1 && out_if.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_word: got 0x%0h expected none", {out_if.out_last, out_if.out_data});
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("word", 32'({out_if.out_last, out_if.out_data}), 32'(e));
            end
            if (out_if.out_last) n_last++;
        end
    end

    // Expected word list for one frame, built from the vector given.
    task automatic push_frame(input logic [BUS_W-1:0] vi, input logic [BUS_W-1:0] vq, input logic sk);
        for (int k = 0; k < int'(N_CH); k++) begin
            logic [1:0] ci, cq;
            logic lst;
            ci  = vi[2*k +: 2];
            cq  = vq[2*k +: 2];
            lst = (k == int'(N_CH) - 1);
            if (!sk || ci != 2'b00 || cq != 2'b00 || lst)
                exp_q.push_back({lst, 4'(k), ci, cq});
        end
    endtask

    task automatic pulse_tick();
        @(posedge clk_master) #1;
        frame_tick = 1'b1;
        @(posedge clk_master) #1;
        frame_tick = 1'b0;
    endtask

    task automatic start_frame(input logic [BUS_W-1:0] vi, input logic [BUS_W-1:0] vq, input logic sk);
        read_out_I = vi;
        read_out_Q = vq;
        skip_zero  = sk;
        exp_fc++;
        pulse_tick();
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        @(negedge clk_master);
        while (busy !== 1'b0 && cyc < 400) begin
            @(negedge clk_master);
            cyc++;
        end
        if (busy !== 1'b0) begin
            n_vec++;
            n_miss++;
            $display("FAIL wait_idle_timeout: busy=%b expected 0", busy);
        end
    endtask

    task automatic wait_valid();
        int cyc;
        cyc = 0;
        @(negedge clk_master);
        while (out_if.out_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk_master);
            cyc++;
        end
        if (out_if.out_valid !== 1'b1) begin
            n_vec++;
            n_miss++;
            $display("FAIL wait_valid_timeout: out_valid=%b expected 1", out_if.out_valid);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid"}, 32'(out_if.out_valid), 32'd0);
        check({name, "_data"},  32'(out_if.out_data),  32'd0);
        check({name, "_last"},  32'(out_if.out_last),  32'd0);
        check({name, "_busy"},  32'(busy),             32'd0);
        check({name, "_ovr"},   32'(overrun),          32'd0);
        check({name, "_fc"},    32'(frame_count),      32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lasts;
        rstb = 1'b0; enable = 1'b1; skip_zero = 1'b0; frame_tick = 1'b0;
        read_out_I = '0; read_out_Q = '0; clr_overrun = 1'b0;
        out_if.out_ready = 1'b1;
        #12;
        check_all_zero("reset");
        @(posedge clk_master) #1;
        rstb = 1'b1;

        // Async reset while a word is held in EMIT; nothing is pushed since ready=0.
        out_if.out_ready = 1'b0;
        read_out_I = 32'hFFFF_FFFF; read_out_Q = 32'hAAAA_AAAA;
        pulse_tick();
        wait_valid();
        #2 rstb = 1'b0;
        #1 check_all_zero("async_reset");
        @(posedge clk_master) #1;
        rstb = 1'b1;
        exp_fc = 0;
        out_if.out_ready = 1'b1;

        // Full frame, no skipping: 16 words in order, last on ch15.
        lasts = n_last;
        push_frame(32'h1B2D_E4C7, 32'h9F03_5A6C, 1'b0);
        start_frame(32'h1B2D_E4C7, 32'h9F03_5A6C, 1'b0);
        wait_idle();
        check("full_frame_lasts", 32'(n_last - lasts), 32'd1);
        check("fc_after_1", 32'(frame_count), 32'd1);

        // Skip mode with only ch3 nonzero: ch3 word then forced ch15 word.
        exp_q.push_back({1'b0, 8'h39});
        exp_q.push_back({1'b1, 8'hF0});
        start_frame(32'h0000_0080, 32'h0000_0040, 1'b1);
        wait_idle();

        // Backpressure on ch0, then ch1 two cycles after release.
        out_if.out_ready = 1'b0;
        push_frame(32'h0000_0007, 32'h0000_000E, 1'b0);
        start_frame(32'h0000_0007, 32'h0000_000E, 1'b0);
        wait_valid();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_master);
            check("bp_valid", 32'(out_if.out_valid), 32'd1);
            check("bp_data", 32'(out_if.out_data), 32'h0E);
        end
        @(posedge clk_master) #1;
        out_if.out_ready = 1'b1;
        @(posedge clk_master) #1;
        check("bp_gap_valid", 32'(out_if.out_valid), 32'd0);
        @(posedge clk_master) #1;
        check("bp_ch1_valid", 32'(out_if.out_valid), 32'd1);
        check("bp_ch1_data", 32'(out_if.out_data), 32'h17);
        wait_idle();

        // Dropped tick while busy sets overrun and leaves frame_count alone.
        push_frame(32'h5555_5555, 32'h3333_3333, 1'b0);
        start_frame(32'h5555_5555, 32'h3333_3333, 1'b0);
        read_out_I = 32'hFFFF_FFFF;
        pulse_tick();
        @(negedge clk_master);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_fc", 32'(frame_count), 32'(8'(exp_fc)));
        @(posedge clk_master) #1;
        clr_overrun = 1'b1;
        @(posedge clk_master) #1;
        clr_overrun = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);
        wait_idle();

        // Clear and dropped tick together: set wins.
        push_frame(32'h0, 32'h0, 1'b0);
        start_frame(32'h0, 32'h0, 1'b0);
        @(posedge clk_master) #1;
        clr_overrun = 1'b1; frame_tick = 1'b1;
        @(posedge clk_master) #1;
        clr_overrun = 1'b0; frame_tick = 1'b0;
        check("ovr_set_wins", 32'(overrun), 32'd1);
        wait_idle();
        @(posedge clk_master) #1;
        clr_overrun = 1'b1;
        @(posedge clk_master) #1;
        clr_overrun = 1'b0;

        // Snapshot isolation: live bus changes after the tick are ignored.
        push_frame(32'h0123_4567, 32'h89AB_CDEF, 1'b0);
        start_frame(32'h0123_4567, 32'h89AB_CDEF, 1'b0);
        read_out_I = 32'hDEAD_BEEF; read_out_Q = 32'h0;
        wait_idle();

        // Enable gating: ticks with enable=0 do nothing.
        enable = 1'b0;
        pulse_tick();
        repeat (3) @(negedge clk_master);
        check("gate_busy", 32'(busy), 32'd0);
        check("gate_ovr", 32'(overrun), 32'd0);
        check("gate_fc", 32'(frame_count), 32'(8'(exp_fc)));

        // Dropping enable mid-frame still completes the frame.
        enable = 1'b1;
        lasts = n_last;
        push_frame(32'h0000_0300, 32'h0, 1'b1);
        start_frame(32'h0000_0300, 32'h0, 1'b1);
        enable = 1'b0;
        wait_idle();
        check("mid_disable_last", 32'(n_last - lasts), 32'd1);
        enable = 1'b1;

        // Counter wrap: run short skip frames until 256 have been accepted.
        while (exp_fc < 256) begin
            push_frame(32'h0, 32'h0, 1'b1);
            start_frame(32'h0, 32'h0, 1'b1);
            wait_idle();
        end
        check("fc_wrap", 32'(frame_count), 32'd0);

        repeat (3) @(negedge clk_master);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
